key_event: RTL and testbench
============================

# key_event

Key event decoder placed directly after the per-key debouncer on the 40 Hz sample clock. It takes the debounced, active-low key level and turns it into single-cycle event pulses for the clock-setting logic: press, short release, long press, auto-repeat while held, and a combined step pulse for increment/advance. It also provides a held level. One instance is used per key.

## Interface

Parameters:
- LONG_TICKS, 40: sample cycles from press_pulse to long_pulse (1 s at 40 Hz). Legal range 2..255.
- REPEAT_TICKS, 8: sample cycles between rep_pulse events after long_pulse (200 ms). Legal range 1..255.

Ports:
- sample_clk, input, 1: the only clock (40 Hz sample clock, shared with the debouncer).
- Reset, input, 1: synchronous, active-high reset.
- keyin, input, 1: debounced key level, active-low (0 = pressed), synchronous to sample_clk.
- held, output, 1: high while the key is recognised as pressed.
- press_pulse, output, 1: one-cycle pulse on a recognised press.
- short_pulse, output, 1: one-cycle pulse on a release that happens before long_pulse.
- long_pulse, output, 1: one-cycle pulse once the hold reaches LONG_TICKS.
- rep_pulse, output, 1: one-cycle pulse every REPEAT_TICKS after long_pulse while the key stays held.
- release_pulse, output, 1: one-cycle pulse on any release, short or long.
- step_pulse, output, 1: press_pulse OR rep_pulse.

## Operation

- Input register: key_q <= keyin every cycle. Reset value of key_q is 0 ("pressed").
- All outputs are registered except step_pulse, which is the OR of two registered signals.
- Hold counter: 8 bits, saturation not required given the legal parameter range. Cleared on every state entry.
- FSM states are ARM, IDLE, HOLD and REPEAT. The reset state is ARM.
- ARM:
  - No pulses are generated.
  - Go to IDLE once key_q == 1.
  - Purpose: a key held through reset is never reported as a press.
- IDLE:
  - If key_q == 0: assert press_pulse and held, then go to HOLD.
- HOLD (key held, still short):
  - If key_q == 1: assert short_pulse and release_pulse, deassert held, go to IDLE.
  - Otherwise count. When the count reaches the LONG_TICKS boundary, assert long_pulse and go to REPEAT.
- REPEAT:
  - If key_q == 1: assert release_pulse (never short_pulse), deassert held, go to IDLE.
  - Otherwise assert rep_pulse every REPEAT_TICKS cycles.
- Release has priority: if key_q == 1 in the cycle that would otherwise produce long_pulse or rep_pulse, only the release pulses are produced.
- After any release, a new press is recognised from IDLE. The minimum gap is one cycle with key_q == 1.
- Reset mid-hold: all outputs drop in the cycle after Reset is sampled and the FSM enters ARM. No release pulse is emitted for the aborted hold.

## Timing

- Reset values: held = 0; all pulses = 0; key_q = 0; state = ARM; counter = 0.
- Cycle numbering: keyin is first sampled 0 at edge E, so key_q = 0 from E.
- Press latency: press_pulse and held are high in the cycle after edge E+1, called cycle P. That is 2 edges from the keyin sample.
- Long press: long_pulse is high in cycle P+LONG_TICKS, provided key_q stayed 0 in cycles P-1 through P+LONG_TICKS-1.
- Auto-repeat: rep_pulse is high in cycles P+LONG_TICKS+n*REPEAT_TICKS, n = 1, 2, …, for as long as key_q stays 0.
- Release latency: if key_q first reads 1 in cycle R (R ≥ P), release_pulse (plus short_pulse if R < P+LONG_TICKS) is high in cycle R+1, and held is low from R+1.
- Pulse width: every pulse is exactly one cycle. press_pulse never coincides with any other pulse except step_pulse.

## Test plan

Bench parameters: LONG_TICKS = 4, REPEAT_TICKS = 2.

- Reset with keyin = 1, then hold keyin = 0 for 3 cycles -> press_pulse at P; short_pulse and release_pulse exactly 1 cycle after key_q returns to 1; no long_pulse; held high for 3 cycles.
- keyin = 0 for 12 cycles -> press_pulse at P; long_pulse at P+4; rep_pulse at P+6, P+8 and P+10; step_pulse at P, P+6, P+8 and P+10; release_pulse only (no short_pulse) after release.
- keyin returns to 1 exactly in cycle P+3 -> short_pulse and release_pulse at P+4; no long_pulse.
- Hold keyin = 0 across assertion and deassertion of Reset for 5 cycles, then release -> no pulse until keyin has been 1 for at least one cycle. A following press yields a normal press_pulse.
- Reset asserted in cycle P+5 of a long hold -> all outputs 0 from the next cycle; no release_pulse; state ARM.
- Press, release for exactly 1 cycle, press again -> two distinct press_pulses, each followed by its own short/release pulses.

Source files
------------

// File: rtl/key_event.sv
// key_event: turns a debounced, active-low key level into single-cycle event
// pulses (press, short release, long press, auto-repeat, any release, step)
// plus a held level. One instance per key, clocked by the 40 Hz sample clock.
//
// Parameters:
//   LONG_TICKS   (2..255) sample cycles from press_pulse to long_pulse
//   REPEAT_TICKS (1..255) sample cycles between rep_pulse events
//
// Ports:
//   sample_clk    in   sample clock
//   Reset         in   synchronous, active-high reset
//   keyin         in   debounced key level, 0 = pressed
//   held          out  high while the key is recognised as pressed
//   press_pulse   out  one cycle on a recognised press
//   short_pulse   out  one cycle on a release before long_pulse
//   long_pulse    out  one cycle when the hold reaches LONG_TICKS
//   rep_pulse     out  one cycle every REPEAT_TICKS after long_pulse
//   release_pulse out  one cycle on any release
//   step_pulse    out  press_pulse | rep_pulse (combinational OR of registers)

module key_event #(
  parameter int unsigned LONG_TICKS   = 40,
  parameter int unsigned REPEAT_TICKS = 8
) (
  input  logic sample_clk,
  input  logic Reset,
  input  logic keyin,
  output logic held,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic rep_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam int unsigned CNT_W = 8;

  // Counter values on the cycle that completes each interval.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             key_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic held_nxt;
  logic press_nxt;
  logic short_nxt;
  logic long_nxt;
  logic rep_nxt;
  logic release_nxt;

  // State, counter, input and output registers.
  always_ff @(posedge sample_clk) begin
    if (Reset) begin
      state         <= ST_ARM;
      key_q         <= 1'b0;
      cnt           <= '0;
      held          <= 1'b0;
      press_pulse   <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      rep_pulse     <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      key_q         <= keyin;
      cnt           <= cnt_nxt;
      held          <= held_nxt;
      press_pulse   <= press_nxt;
      short_pulse   <= short_nxt;
      long_pulse    <= long_nxt;
      rep_pulse     <= rep_nxt;
      release_pulse <= release_nxt;
    end
  end

  // Next-state, counter and pulse decode. Release is tested first in HOLD and
  // REPEAT so it wins over a coincident long/repeat boundary.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    held_nxt    = 1'b0;
    press_nxt   = 1'b0;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;
    rep_nxt     = 1'b0;
    release_nxt = 1'b0;

    case (state)
      // Wait for the key to be seen released so a key held through reset
      // never produces a press.
      ST_ARM: begin
        if (key_q) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end

      ST_IDLE: begin
        if (!key_q) begin
          press_nxt = 1'b1;
          held_nxt  = 1'b1;
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      end

      ST_HOLD: begin
        if (key_q) begin
          short_nxt   = 1'b1;
          release_nxt = 1'b1;
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
        end else if (cnt == LONG_LAST) begin
          held_nxt  = 1'b1;
          long_nxt  = 1'b1;
          state_nxt = ST_REPEAT;
          cnt_nxt   = '0;
        end else begin
          held_nxt = 1'b1;
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end

      ST_REPEAT: begin
        if (key_q) begin
          release_nxt = 1'b1;
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
        end else if (cnt == REP_LAST) begin
          held_nxt = 1'b1;
          rep_nxt  = 1'b1;
          cnt_nxt  = '0;
        end else begin
          held_nxt = 1'b1;
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_ARM;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign step_pulse = press_pulse | rep_pulse;

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event with LONG_TICKS = 4, REPEAT_TICKS = 2.
// A reference model tracks the key as "armed / down / age since press" and
// predicts every output each cycle; directed scenarios are followed by
// randomized key activity with occasional resets.

module tb_key_event;

  localparam int LONG = 4;
  localparam int REP  = 2;

  logic clk;
  logic rst;
  logic keyin;
  logic held;
  logic press_pulse;
  logic short_pulse;
  logic long_pulse;
  logic rep_pulse;
  logic release_pulse;
  logic step_pulse;

  key_event #(
    .LONG_TICKS  (LONG),
    .REPEAT_TICKS(REP)
  ) dut (
    .sample_clk   (clk),
    .Reset        (rst),
    .keyin        (keyin),
    .held         (held),
    .press_pulse  (press_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .rep_pulse    (rep_pulse),
    .release_pulse(release_pulse),
    .step_pulse   (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit m_kq;
  bit m_armed;
  bit m_down;
  int m_age;
  bit e_held, e_press, e_short, e_long, e_rep, e_release, e_step;

  // Observed pulse counts over a scenario window
  int n_press, n_short, n_long, n_rep, n_release;

  task automatic model_edge(input bit k, input bit r);
    e_press   = 1'b0;
    e_short   = 1'b0;
    e_long    = 1'b0;
    e_rep     = 1'b0;
    e_release = 1'b0;
    if (r) begin
      m_armed = 1'b0;
      m_down  = 1'b0;
      m_age   = 0;
      m_kq    = 1'b0;
    end else begin
      if (!m_armed) begin
        if (m_kq) m_armed = 1'b1;
      end else if (!m_down) begin
        if (!m_kq) begin
          e_press = 1'b1;
          m_down  = 1'b1;
          m_age   = 0;
        end
      end else if (m_kq) begin
        e_release = 1'b1;
        e_short   = (m_age < LONG);
        m_down    = 1'b0;
      end else begin
        m_age  = m_age + 1;
        e_long = (m_age == LONG);
        e_rep  = (m_age > LONG) && (((m_age - LONG) % REP) == 0);
      end
      m_kq = k;
    end
    e_held = m_down;
    e_step = e_press | e_rep;
  endtask

  task automatic clear_counts();
    n_press = 0; n_short = 0; n_long = 0; n_rep = 0; n_release = 0;
  endtask

  // One sample cycle: drive at negedge, model at posedge, compare at negedge.
  task automatic apply(input bit k, input bit r, input string tag);
    logic [6:0] obs;
    logic [6:0] expv;
    keyin = k;
    rst   = r;
    @(posedge clk);
    model_edge(k, r);
    @(negedge clk);
    obs  = {held, press_pulse, short_pulse, long_pulse, rep_pulse, release_pulse, step_pulse};
    expv = {e_held, e_press, e_short, e_long, e_rep, e_release, e_step};
    n_press   += int'(press_pulse);
    n_short   += int'(short_pulse);
    n_long    += int'(long_pulse);
    n_rep     += int'(rep_pulse);
    n_release += int'(release_pulse);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed hold/prs/sht/lng/rep/rel/stp=%b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_count(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed count %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic run(input bit k, input int n, input string tag);
    for (int i = 0; i < n; i++) apply(k, 1'b0, tag);
  endtask

  initial begin
    keyin = 1'b1;
    rst   = 1'b1;
    @(negedge clk);

    // Reset with key released, then arm
    apply(1'b1, 1'b1, "reset");
    apply(1'b1, 1'b1, "reset");
    run(1'b1, 3, "arm");

    // Short press of 3 cycles
    clear_counts();
    run(1'b0, 3, "short3");
    run(1'b1, 4, "short3_rel");
    check_count("short3_press", n_press, 1);
    check_count("short3_short", n_short, 1);
    check_count("short3_long", n_long, 0);
    check_count("short3_release", n_release, 1);

    // Long hold of 12 cycles with auto-repeat
    clear_counts();
    run(1'b0, 12, "long12");
    run(1'b1, 4, "long12_rel");
    check_count("long12_press", n_press, 1);
    check_count("long12_long", n_long, 1);
    check_count("long12_rep", n_rep, 3);
    check_count("long12_short", n_short, 0);
    check_count("long12_release", n_release, 1);

    // Release on the cycle that would have produced long_pulse
    clear_counts();
    run(1'b0, 4, "edge_long");
    run(1'b1, 3, "edge_long_rel");
    check_count("edge_long_short", n_short, 1);
    check_count("edge_long_long", n_long, 0);

    // Key held across reset: no press until seen released
    clear_counts();
    run(1'b0, 2, "hold_rst_pre");
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, "hold_rst");
    run(1'b0, 3, "hold_rst_post");
    check_count("hold_rst_nopress", n_press, 1);
    run(1'b1, 1, "hold_rst_gap");
    run(1'b0, 3, "hold_rst_press");
    run(1'b1, 3, "hold_rst_rel");
    check_count("hold_rst_press2", n_press, 2);

    // Reset in the middle of a long hold: no release pulse
    clear_counts();
    run(1'b0, 6, "mid_rst_hold");
    apply(1'b0, 1'b1, "mid_rst");
    run(1'b1, 3, "mid_rst_after");
    check_count("mid_rst_release", n_release, 0);
    check_count("mid_rst_long", n_long, 1);

    // Press, one-cycle gap, press again
    clear_counts();
    run(1'b0, 2, "dbl_a");
    run(1'b1, 1, "dbl_gap");
    run(1'b0, 2, "dbl_b");
    run(1'b1, 3, "dbl_rel");
    check_count("dbl_press", n_press, 2);
    check_count("dbl_short", n_short, 2);

    // Randomized key activity with occasional resets
    for (int b = 0; b < 80; b++) begin
      bit k;
      int len;
      k   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      for (int i = 0; i < len; i++) begin
        apply(k, ($urandom_range(0, 59) == 0), "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
